// File: rtl/comparator_minmax_tracker.sv
// Streaming running min/max tracker with per-run signed/unsigned mode,
// saturating sample count and a single registered valid/ready output stage.
module comparator_minmax_tracker #(
    parameter int N       = 32,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N-1:0]       in_data,
    input  logic               is_signed,
    input  logic               clear,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N-1:0]       out_min,
    output logic [N-1:0]       out_max,
    output logic [COUNT_W-1:0] out_count,
    output logic               out_new_min,
    output logic               out_new_max,
    output logic               out_signed
);
    typedef enum logic [0:0] { ST_EMPTY = 1'b0, ST_TRACKING = 1'b1 } state_t;

    localparam logic [COUNT_W-1:0] COUNT_MAX  = {COUNT_W{1'b1}};
    localparam logic [COUNT_W-1:0] COUNT_ONE  = COUNT_W'(1'b1);
    localparam logic [COUNT_W-1:0] COUNT_ZERO = {COUNT_W{1'b0}};

    // Flipping the MSB maps two's complement order onto unsigned order, so a
    // single N-bit magnitude compare is exact in both modes.
    function automatic logic less_than(input logic [N-1:0] a, input logic [N-1:0] b,
                                       input logic signed_mode);
        logic [N-1:0] a_key;
        logic [N-1:0] b_key;
        a_key = {a[N-1] ^ signed_mode, a[N-2:0]};
        b_key = {b[N-1] ^ signed_mode, b[N-2:0]};
        return a_key < b_key;
    endfunction

    state_t               state_r, state_s;
    logic [N-1:0]         min_r, min_s, max_r, max_s;
    logic [COUNT_W-1:0]   count_r, count_s;
    logic                 mode_r, mode_s;
    logic                 accept_s, lt_s, gt_s, new_min_s, new_max_s;
    logic                 out_valid_r, out_valid_s;
    logic [N-1:0]         out_min_r, out_max_r;
    logic [COUNT_W-1:0]   out_count_r;
    logic                 out_new_min_r, out_new_max_r, out_signed_r;

    assign in_ready    = !rst && (!out_valid_r || out_ready);
    assign accept_s    = in_valid && in_ready;
    assign out_valid   = out_valid_r;
    assign out_min     = out_min_r;
    assign out_max     = out_max_r;
    assign out_count   = out_count_r;
    assign out_new_min = out_new_min_r;
    assign out_new_max = out_new_max_r;
    assign out_signed  = out_signed_r;

    // Next-state for the run FSM and tracked extremes; clear beats an accept.
    always_comb begin
        state_s   = state_r;
        min_s     = min_r;
        max_s     = max_r;
        count_s   = count_r;
        mode_s    = mode_r;
        new_min_s = 1'b0;
        new_max_s = 1'b0;
        lt_s      = less_than(in_data, min_r, mode_r);
        gt_s      = less_than(max_r, in_data, mode_r);
        if (accept_s && (clear || (state_r == ST_EMPTY))) begin
            state_s   = ST_TRACKING;
            min_s     = in_data;
            max_s     = in_data;
            count_s   = COUNT_ONE;
            mode_s    = is_signed;
            new_min_s = 1'b1;
            new_max_s = 1'b1;
        end else if (accept_s) begin
            if (lt_s) min_s = in_data;
            else      min_s = min_r;
            if (gt_s) max_s = in_data;
            else      max_s = max_r;
            new_min_s = lt_s;
            new_max_s = gt_s;
            if (count_r == COUNT_MAX) count_s = count_r;
            else                      count_s = count_r + COUNT_ONE;
        end else if (clear) begin
            state_s = ST_EMPTY;
            count_s = COUNT_ZERO;
        end else begin
            state_s = state_r;
        end
    end

    // Output valid: set by an accept, dropped by a handshake, held under stall.
    always_comb begin
        out_valid_s = out_valid_r;
        if (accept_s)       out_valid_s = 1'b1;
        else if (out_ready) out_valid_s = 1'b0;
        else                out_valid_s = out_valid_r;
    end

    // Run state and output stage registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_EMPTY;
            min_r         <= {N{1'b0}};
            max_r         <= {N{1'b0}};
            count_r       <= COUNT_ZERO;
            mode_r        <= 1'b0;
            out_valid_r   <= 1'b0;
            out_min_r     <= {N{1'b0}};
            out_max_r     <= {N{1'b0}};
            out_count_r   <= COUNT_ZERO;
            out_new_min_r <= 1'b0;
            out_new_max_r <= 1'b0;
            out_signed_r  <= 1'b0;
        end else begin
            state_r     <= state_s;
            min_r       <= min_s;
            max_r       <= max_s;
            count_r     <= count_s;
            mode_r      <= mode_s;
            out_valid_r <= out_valid_s;
            if (accept_s) begin
                out_min_r     <= min_s;
                out_max_r     <= max_s;
                out_count_r   <= count_s;
                out_new_min_r <= new_min_s;
                out_new_max_r <= new_max_s;
                out_signed_r  <= mode_s;
            end else begin
                out_min_r     <= out_min_r;
                out_max_r     <= out_max_r;
                out_count_r   <= out_count_r;
                out_new_min_r <= out_new_min_r;
                out_new_max_r <= out_new_max_r;
                out_signed_r  <= out_signed_r;
            end
        end
    end
endmodule
